// File: rtl/tdm_demux_18.sv
// Receive end of the 8:1 slot-multiplexed link: strobed serial slots in, registered 8-lane frame out.
// Optional build macro TDM_DEMUX_FREE_RUN_EN: once locked, a sync-less slot 0 is accepted (else framing error).
module tdm_demux_18 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   din,
  input  logic               en,
  input  logic               sync,
  output logic [8*WIDTH-1:0] y,
  output logic               frame_valid,
  output logic [2:0]         slot,
  output logic               err,
  output logic               locked
);

  // state | meaning
  // IDLE  | not aligned; sync-less strobes are dropped
  // RUN   | aligned; slots steered into the shadow register
  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              slot_q, slot_d;
  logic [6:0][WIDTH-1:0]   shadow_q, shadow_d;
  logic [8*WIDTH-1:0]      y_q, y_d;
  logic                    fv_q, fv_d;
  logic                    err_q, err_d;
  logic                    locked_q, locked_d;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    y_d      = y_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;

    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (sync) begin
            shadow_d[0] = din;
            slot_d      = 3'd1;
            state_d     = RUN;
          end
        end
        RUN: begin
          if (sync) begin
            // early sync abandons the partial frame; din restarts as slot 0
            err_d       = (slot_q != 3'd0);
            shadow_d[0] = din;
            slot_d      = 3'd1;
          end else if (slot_q == 3'd0) begin
`ifdef TDM_DEMUX_FREE_RUN_EN
            shadow_d[0] = din;
            slot_d      = 3'd1;
`else
            err_d       = 1'b1;
            state_d     = IDLE;
`endif
          end else if (slot_q == 3'd7) begin
            // lane 7 bypasses the shadow so the frame lands on this edge
            y_d    = {din, shadow_q};
            fv_d   = 1'b1;
            slot_d = 3'd0;
          end else begin
            for (int k = 1; k < 7; k++) begin
              if (slot_q == 3'(k)) shadow_d[k] = din;
            end
            slot_d = slot_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    locked_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      shadow_q <= '0;
      y_q      <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      y_q      <= y_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign y           = y_q;
  assign frame_valid = fv_q;
  assign slot        = slot_q;
  assign err         = err_q;
  assign locked      = locked_q;

endmodule
